// File: rtl/irq_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : irq_responder_if
// Description : CPU-side interrupt handshake bundle (req/vector/ack/eoi/in-service).
//               The slave modport is the responder; the master modport is the CPU.
// Revision    : 1.0 - initial release
// ============================================================================
interface irq_responder_if #(
    parameter int VW = 4
);
    logic          int_req;
    logic [VW-1:0] int_vec;
    logic          int_ack;
    logic          int_eoi;
    logic          in_service;

    modport slave (
        output int_req,
        output int_vec,
        output in_service,
        input  int_ack,
        input  int_eoi
    );

    modport master (
        input  int_req,
        input  int_vec,
        input  in_service,
        output int_ack,
        output int_eoi
    );
endinterface
`default_nettype wire

// File: rtl/irq_responder.sv
`default_nettype none
// ============================================================================
// Module      : irq_responder
// Description : Sequential priority interrupt responder. Latches request edges
//               into sticky pending bits, arbitrates by fixed priority (channel 0
//               highest), presents the winner over a req/ack handshake and holds
//               it in service until end-of-interrupt. All outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_responder #(
    parameter int NCH = 9,
    parameter int VW  = 4
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    input  wire logic [NCH-1:0] irq_in,
    input  wire logic [NCH-1:0] irq_mask,
    output logic      [NCH-1:0] pending,
    output logic      [NCH-1:0] ovf,
    input  wire logic           ovf_clr,
    irq_responder_if.slave      cpu
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [NCH-1:0] r_irq_q;
    logic [NCH-1:0] r_pending;
    logic [NCH-1:0] r_ovf;
    logic           r_int_req;
    logic [VW-1:0]  r_int_vec;
    logic           r_in_service;

    logic [NCH-1:0] w_rise;
    logic [NCH-1:0] w_elig;
    logic [NCH-1:0] w_clr;
    logic [VW-1:0]  w_win;
    logic           w_take_ack;
    logic           w_req_nxt;
    logic [VW-1:0]  w_vec_nxt;
    logic           w_insvc_nxt;

    assign w_rise     = irq_in & ~r_irq_q;
    assign w_elig     = r_pending & ~irq_mask;
    assign w_take_ack = (r_state == ST_REQ) && cpu.int_ack;
    // Ack clears only the channel currently being presented.
    assign w_clr      = w_take_ack ? (NCH'(1) << r_int_vec) : '0;

    // Fixed priority: scanning downward leaves the lowest eligible index.
    always_comb begin
        w_win = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_win = VW'(i);
            end
        end
    end

    // Handshake next-state and next-output decode.
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_int_req;
        w_vec_nxt   = r_int_vec;
        w_insvc_nxt = r_in_service;
        case (r_state)
            ST_IDLE: begin
                if (|w_elig) begin
                    w_vec_nxt   = w_win;
                    w_req_nxt   = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                // Vector stays frozen until acknowledged; no withdrawal.
                if (cpu.int_ack) begin
                    w_req_nxt   = 1'b0;
                    w_insvc_nxt = 1'b1;
                    w_state_nxt = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (cpu.int_eoi) begin
                    w_insvc_nxt = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_req_nxt   = 1'b0;
                w_insvc_nxt = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and handshake output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_int_req    <= 1'b0;
            r_int_vec    <= '0;
            r_in_service <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_int_req    <= w_req_nxt;
            r_int_vec    <= w_vec_nxt;
            r_in_service <= w_insvc_nxt;
        end
    end

    // Edge history, sticky pending and overflow flags. A fresh rise beats a
    // same-cycle ack clear, and that case is not an overflow because the old
    // request is being consumed at that very edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_q   <= '0;
            r_pending <= '0;
            r_ovf     <= '0;
        end else begin
            r_irq_q   <= irq_in;
            r_pending <= (r_pending & ~w_clr) | w_rise;
            r_ovf     <= (ovf_clr ? '0 : r_ovf) | (w_rise & r_pending & ~w_clr);
        end
    end

    assign pending        = r_pending;
    assign ovf            = r_ovf;
    assign cpu.int_req    = r_int_req;
    assign cpu.int_vec    = r_int_vec;
    assign cpu.in_service = r_in_service;

endmodule
`default_nettype wire

// File: tb/tb_irq_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_responder
// Description : Self-checking bench for irq_responder: directed scenarios then
//               randomized traffic against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_responder;
    localparam int NCH = 9;
    localparam int VW  = 4;

    logic           clk     = 1'b0;
    logic           rst_n   = 1'b1;
    logic [NCH-1:0] irq_in  = '0;
    logic [NCH-1:0] irq_mask = '0;
    logic           ovf_clr = 1'b0;
    logic [NCH-1:0] pending;
    logic [NCH-1:0] ovf;

    int n_checks = 0;
    int n_errors = 0;

    irq_responder_if #(.VW(VW)) cpu ();

    irq_responder #(.NCH(NCH), .VW(VW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq_in   (irq_in),
        .irq_mask (irq_mask),
        .pending  (pending),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr),
        .cpu      (cpu.slave)
    );

    always #5 clk = ~clk;

    // Reference model: per-channel flags plus a phase number
    // (0 = waiting for work, 1 = requesting, 2 = being serviced).
    bit m_prev [NCH];
    bit m_pend [NCH];
    bit m_ovf  [NCH];
    int m_phase;
    int m_vec;
    bit m_req;
    bit m_insvc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input bit a [NCH]);
        logic [31:0] v = '0;
        for (int i = 0; i < NCH; i++) v[i] = a[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_prev[i] = 0; m_pend[i] = 0; m_ovf[i] = 0;
        end
        m_phase = 0; m_vec = 0; m_req = 0; m_insvc = 0;
    endtask

    task automatic model_step();
        bit np [NCH];
        bit no [NCH];
        int win;
        for (int i = 0; i < NCH; i++) begin
            bit rise, acked;
            rise  = irq_in[i] && !m_prev[i];
            acked = (m_phase == 1) && cpu.int_ack && (m_vec == i);
            np[i] = rise || (m_pend[i] && !acked);
            no[i] = (m_ovf[i] && !ovf_clr) || (rise && m_pend[i] && !acked);
        end
        if (m_phase == 0) begin
            win = -1;
            for (int i = 0; i < NCH; i++)
                if (win < 0 && m_pend[i] && !irq_mask[i]) win = i;
            if (win >= 0) begin
                m_vec = win; m_req = 1; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (cpu.int_ack) begin
                m_req = 0; m_insvc = 1; m_phase = 2;
            end
        end else begin
            if (cpu.int_eoi) begin
                m_insvc = 0; m_phase = 0;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            m_pend[i] = np[i]; m_ovf[i] = no[i]; m_prev[i] = irq_in[i];
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".req"},   cpu.int_req,    m_req);
        chk({tag, ".vec"},   cpu.int_vec,    m_vec);
        chk({tag, ".insvc"}, cpu.in_service, m_insvc);
        chk({tag, ".pend"},  pending,        pack(m_pend));
        chk({tag, ".ovf"},   ovf,            pack(m_ovf));
    endtask

    // One clock: inputs were set at the preceding negedge.
    task automatic cycle(input string tag);
        @(posedge clk);
        model_step();
        #1;
        compare_all(tag);
        @(negedge clk);
    endtask

    task automatic drive(input logic [NCH-1:0] irq, input logic ack, input logic eoi);
        irq_in = irq; cpu.int_ack = ack; cpu.int_eoi = eoi;
    endtask

    // Reset asserted between edges; outputs must fall without a clock.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst.req",   cpu.int_req,    0);
        chk("arst.pend",  pending,        0);
        chk("arst.insvc", cpu.in_service, 0);
        chk("arst.ovf",   ovf,            0);
        chk("arst.vec",   cpu.int_vec,    0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        cpu.int_ack = 1'b0;
        cpu.int_eoi = 1'b0;
        model_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        compare_all("reset");

        // Single request on channel 5.
        drive(9'h020, 0, 0); cycle("s5a");
        chk("s5.pend_set", pending, 32'h020);
        drive(9'h000, 0, 0); cycle("s5b");
        chk("s5.req", cpu.int_req, 1);
        chk("s5.vec", cpu.int_vec, 5);
        drive(9'h000, 1, 0); cycle("s5ack");
        chk("s5.pend_clr", pending, 0);
        chk("s5.insvc", cpu.in_service, 1);
        drive(9'h000, 0, 1); cycle("s5eoi");
        chk("s5.insvc0", cpu.in_service, 0);
        drive(9'h000, 0, 0); cycle("s5idle");

        // Priority and vector freeze.
        drive(9'h088, 0, 0); cycle("p0");
        drive(9'h000, 0, 0); cycle("p1");
        chk("prio.vec3", cpu.int_vec, 3);
        drive(9'h001, 0, 0); cycle("p2");
        drive(9'h000, 0, 0); cycle("p3");
        chk("freeze.vec3", cpu.int_vec, 3);
        drive(9'h000, 1, 0); cycle("p4");
        drive(9'h000, 0, 1); cycle("p5");
        drive(9'h000, 0, 0); cycle("p6");
        chk("prio.vec0", cpu.int_vec, 0);
        drive(9'h000, 1, 0); cycle("p7");
        drive(9'h000, 0, 1); cycle("p8");
        drive(9'h000, 0, 0); cycle("p9");
        chk("prio.vec7", cpu.int_vec, 7);
        drive(9'h000, 1, 0); cycle("p10");
        drive(9'h000, 0, 1); cycle("p11");
        drive(9'h000, 0, 0); cycle("p12");

        // Masked channel latches pending but does not request.
        irq_mask = 9'h004;
        drive(9'h004, 0, 0); cycle("m0");
        drive(9'h000, 0, 0); cycle("m1");
        cycle("m2");
        chk("mask.noreq", cpu.int_req, 0);
        chk("mask.pend",  pending[2], 1);
        irq_mask = 9'h000;
        cycle("m3");
        chk("unmask.req", cpu.int_req, 1);
        chk("unmask.vec", cpu.int_vec, 2);
        drive(9'h000, 1, 0); cycle("m4");
        drive(9'h000, 0, 1); cycle("m5");
        drive(9'h000, 0, 0); cycle("m6");

        // Overflow, single service, clear.
        drive(9'h010, 0, 0); cycle("o0");
        drive(9'h000, 0, 0); cycle("o1");
        drive(9'h010, 0, 0); cycle("o2");
        drive(9'h000, 0, 0); cycle("o3");
        chk("ovf.set", ovf, 32'h010);
        drive(9'h000, 1, 0); cycle("o4");
        drive(9'h000, 0, 1); cycle("o5");
        drive(9'h000, 0, 0); cycle("o6");
        chk("ovf.oneservice", cpu.int_req, 0);
        ovf_clr = 1'b1; cycle("o7");
        ovf_clr = 1'b0;
        chk("ovf.clr", ovf, 0);

        // Rise coincident with ack of the same channel.
        drive(9'h010, 0, 0); cycle("c0");
        drive(9'h000, 0, 0); cycle("c1");
        drive(9'h010, 1, 0); cycle("c2");
        chk("coinc.pend", pending[4], 1);
        chk("coinc.ovf",  ovf, 0);
        drive(9'h000, 0, 1); cycle("c3");
        drive(9'h000, 0, 0); cycle("c4");
        chk("coinc.rearb", cpu.int_vec, 4);
        drive(9'h000, 1, 0); cycle("c5");
        drive(9'h000, 0, 1); cycle("c6");
        drive(9'h000, 0, 0); cycle("c7");

        // Stray ack/eoi and held level.
        drive(9'h000, 1, 1); cycle("r0");
        chk("stray.idle", cpu.int_req | cpu.in_service, 0);
        drive(9'h040, 0, 0); cycle("r1");
        drive(9'h040, 0, 1); cycle("r2");
        chk("stray.eoi_req", cpu.int_req, 1);
        drive(9'h040, 1, 0); cycle("r3");
        drive(9'h040, 1, 0); cycle("r4");
        chk("stray.ack_svc", cpu.in_service, 1);
        drive(9'h040, 0, 1); cycle("r5");
        drive(9'h040, 0, 0); cycle("r6");
        cycle("r7");
        chk("held.once", pending, 0);
        drive(9'h000, 0, 0); cycle("r8");

        // Async reset mid-REQ with channel 1 held high.
        drive(9'h002, 0, 0); cycle("a0");
        cycle("a1");
        async_reset();
        cycle("a2");
        cycle("a3");
        chk("arst.rereq", cpu.int_req, 1);
        chk("arst.vec1",  cpu.int_vec, 1);
        drive(9'h000, 1, 0); cycle("a4");
        drive(9'h000, 0, 1); cycle("a5");
        drive(9'h000, 0, 0); cycle("a6");

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [NCH-1:0] r;
            for (int i = 0; i < NCH; i++) r[i] = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 31) == 0) irq_mask = NCH'($urandom) & NCH'($urandom);
            ovf_clr = ($urandom_range(0, 19) == 0);
            drive(r, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            cycle("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
`default_nettype wire
